// File: rtl/encode_div_64s_25ns_40_seq.sv
`default_nettype none
// ============================================================================
// Module   : encode_div_64s_25ns_40_seq
// Purpose  : Restoring signed/unsigned divider with start/ready/done and ce stall.
//            It produces a saturated signed quotient and a signed remainder.
// Revision : 1.0
// ============================================================================
module encode_div_64s_25ns_40_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 64,
    parameter int din1_WIDTH = 25,
    parameter int dout_WIDTH = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem,
    output logic                  ovf,
    output logic                  div0
);

    localparam int CW = $clog2(din0_WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CW-1:0]         C_LAST    = CW'(din0_WIDTH - 1);
    localparam logic [dout_WIDTH-1:0] C_MAX     = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] C_MIN     = {1'b1, {(dout_WIDTH-1){1'b0}}};
    localparam logic [din0_WIDTH-1:0] C_POS_MAG = {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic [din0_WIDTH-1:0] C_NEG_MAG = C_POS_MAG + din0_WIDTH'(1);

    // ID is an instance tag only; a negative value has no meaning.
    if (ID < 0) begin : g_id_invalid
    end

    logic [1:0]            state_q, state_d;
    logic [din0_WIDTH-1:0] dq_q, dq_d;      // dividend bits shift out, quotient bits shift in
    logic [din1_WIDTH-1:0] dvs_q, dvs_d;
    logic [din1_WIDTH-1:0] part_q, part_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  zero_q, zero_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
    logic [din1_WIDTH:0]   rem_q, rem_d;
    logic                  ovf_q, ovf_d;
    logic                  div0_q, div0_d;

    logic [din0_WIDTH-1:0] w_mag;
    logic [din1_WIDTH:0]   w_shift;
    logic [din1_WIDTH:0]   w_sub;
    logic                  w_ge;
    logic [dout_WIDTH-1:0] w_qlo;

    // Unsigned magnitude: -2^(W-1) maps to 2^(W-1), which still fits.
    assign w_mag   = din0[din0_WIDTH-1] ? -din0 : din0;
    assign w_shift = {part_q, dq_q[din0_WIDTH-1]};
    assign w_sub   = w_shift - {1'b0, dvs_q};
    assign w_ge    = (w_shift >= {1'b0, dvs_q});
    assign w_qlo   = dq_q[dout_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        div0_d  = div0_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dq_d    = w_mag;
                    dvs_d   = din1;
                    neg_d   = din0[din0_WIDTH-1];
                    zero_d  = (din1 == '0);
                    part_d  = '0;
                    cnt_d   = '0;
                    state_d = (din1 == '0) ? S_FIXUP : S_BUSY;
                end
            end
            S_BUSY: begin
                part_d = din1_WIDTH'(w_ge ? w_sub : w_shift);
                dq_d   = {dq_q[din0_WIDTH-2:0], w_ge};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == C_LAST) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                state_d = S_DONE;
                if (zero_q) begin
                    dout_d = neg_q ? C_MIN : C_MAX;
                    rem_d  = '0;
                    ovf_d  = 1'b1;
                    div0_d = 1'b1;
                end else begin
                    div0_d = 1'b0;
                    rem_d  = neg_q ? -{1'b0, part_q} : {1'b0, part_q};
                    // A negative result may reach exactly -2^(dout-1) without saturating.
                    if (!neg_q && (dq_q > C_POS_MAG)) begin
                        dout_d = C_MAX;
                        ovf_d  = 1'b1;
                    end else if (neg_q && (dq_q > C_NEG_MAG)) begin
                        dout_d = C_MIN;
                        ovf_d  = 1'b1;
                    end else begin
                        dout_d = neg_q ? -w_qlo : w_qlo;
                        ovf_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dq_q    <= '0;
            dvs_q   <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            div0_q  <= div0_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = (state_q == S_DONE);
    assign dout  = dout_q;
    assign rem   = rem_q;
    assign ovf   = ovf_q;
    assign div0  = div0_q;

endmodule
`default_nettype wire
